// File: rtl/qr_stream_ctrl.sv
// Buffers one NUM_COL-beat matrix between the stream FIFOs and a QR_CORDIC engine so the
// engine sees a gap-free input burst and never sees output backpressure.
module qr_stream_ctrl #(
    parameter int TBITS       = 64,
    parameter int TBYTE       = 8,
    parameter int DATA_LENGTH = 13,
    parameter int NUM_COL     = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_en,
    input  logic [TBITS-1:0]         isif_data_dout,
    input  logic                     isif_last_dout,
    input  logic                     isif_empty_n,
    output logic                     isif_read,
    output logic [TBITS-1:0]         osif_data_din,
    output logic [TBYTE-1:0]         osif_strb_din,
    output logic                     osif_last_din,
    output logic                     osif_user_din,
    input  logic                     osif_full_n,
    output logic                     osif_write,
    output logic                     qr_in_valid,
    output logic [4*DATA_LENGTH-1:0] qr_in_data,
    input  logic                     qr_out_valid,
    input  logic [4*DATA_LENGTH-1:0] qr_out_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err_len,
    output logic                     err_timeout,
    output logic [15:0]              mat_cnt
);

    localparam int DW = 4 * DATA_LENGTH;
    localparam int CW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(NUM_COL - 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic [DW-1:0] ibuf [NUM_COL];
    logic [DW-1:0] obuf [NUM_COL];
    logic          pop;
    logic          cap;

    assign pop           = (state == S_LOAD) && isif_empty_n;
    assign cap           = (state == S_WAIT) && qr_out_valid;
    assign isif_read     = pop;
    assign osif_write    = (state == S_DRAIN) && osif_full_n;
    assign osif_data_din = (state == S_DRAIN) ? TBITS'(obuf[cnt]) : '0;
    assign osif_strb_din = '1;
    assign osif_user_din = (state == S_DRAIN) && (cnt == '0);
    assign osif_last_din = (state == S_DRAIN) && (cnt == CNT_LAST);
    assign busy          = (state != S_IDLE);

    generate
        if (TBITS > DW) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^isif_data_dout[TBITS-1:DW];
        end
    endgenerate

    // NOTE: buffer storage has no reset; its contents are only read after being written,
    // so leaving it out of the reset keeps it plain RAM/flops without a reset network.
    always_ff @(posedge clk) begin
        if (pop) ibuf[cnt] <= isif_data_dout[DW-1:0];
        if (cap) obuf[cnt] <= qr_out_data;
    end

    // NOTE: every register here uses non-blocking assignment so all next-state values are
    // computed from the pre-edge state, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            tcnt        <= '0;
            qr_in_valid <= 1'b0;
            qr_in_data  <= '0;
            done        <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            mat_cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_en && isif_empty_n) begin
                        state <= S_LOAD;
                        cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    if (pop) begin
                        if (cnt == CNT_LAST) begin
                            if (!isif_last_dout) err_len <= 1'b1;
                            // qr_in_valid rises with FEED so it is high exactly NUM_COL cycles
                            state       <= S_FEED;
                            cnt         <= '0;
                            qr_in_valid <= 1'b1;
                            qr_in_data  <= ibuf[0];
                        end else if (isif_last_dout) begin
                            err_len <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_FEED: begin
                    if (cnt == CNT_LAST) begin
                        qr_in_valid <= 1'b0;
                        state       <= S_WAIT;
                        cnt         <= '0;
                        tcnt        <= '0;
                    end else begin
                        cnt        <= cnt + CW'(1);
                        qr_in_data <= ibuf[cnt + CW'(1)];
                    end
                end
                S_WAIT: begin
                    if (qr_out_valid) begin
                        tcnt <= '0;
                        if (cnt == CNT_LAST) begin
                            state <= S_DRAIN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (tcnt == TCNT_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_DRAIN: begin
                    if (osif_full_n) begin
                        if (cnt == CNT_LAST) begin
                            done    <= 1'b1;
                            mat_cnt <= mat_cnt + 16'd1;
                            state   <= S_IDLE;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qr_stream_ctrl.sv
// Self-checking bench for qr_stream_ctrl: FIFO and engine models driven from one initial
// block, results compared against a transaction-level reference of the matrix flow.
module tb_qr_stream_ctrl;

    localparam int NC = 8;
    localparam int DW = 52;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic          clk;
    logic          rst;
    logic          cfg_en;
    logic [63:0]   isif_data_dout;
    logic          isif_last_dout;
    logic          isif_empty_n;
    logic          isif_read;
    logic [63:0]   osif_data_din;
    logic [7:0]    osif_strb_din;
    logic          osif_last_din;
    logic          osif_user_din;
    logic          osif_full_n;
    logic          osif_write;
    logic          qr_in_valid;
    logic [DW-1:0] qr_in_data;
    logic          qr_out_valid;
    logic [DW-1:0] qr_out_data;
    logic          busy;
    logic          done;
    logic          err_len;
    logic          err_timeout;
    logic [15:0]   mat_cnt;

    qr_stream_ctrl #(.TBITS(64), .TBYTE(8), .DATA_LENGTH(13), .NUM_COL(NC), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en),
        .isif_data_dout(isif_data_dout), .isif_last_dout(isif_last_dout),
        .isif_empty_n(isif_empty_n), .isif_read(isif_read),
        .osif_data_din(osif_data_din), .osif_strb_din(osif_strb_din),
        .osif_last_din(osif_last_din), .osif_user_din(osif_user_din),
        .osif_full_n(osif_full_n), .osif_write(osif_write),
        .qr_in_valid(qr_in_valid), .qr_in_data(qr_in_data),
        .qr_out_valid(qr_out_valid), .qr_out_data(qr_out_data),
        .busy(busy), .done(done), .err_len(err_len), .err_timeout(err_timeout),
        .mat_cnt(mat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // stimulus-side state, owned by the initial block
    int          cyc = 0;
    beat_t       in_q [$];
    logic [DW-1:0] rq [$];
    int          rd [$];
    logic [DW-1:0] cur_w [NC];
    bit          in_stall, tog, rnd_bp, eng_on, eng_gaps;
    int          lat, bp_left, gap_run, exp_mat;

    // monitor-side state, owned by the negedge process
    logic          mon_pop = 1'b0;
    logic          mon_in_valid = 1'b0;
    logic [DW-1:0] mon_in_data = '0;
    logic          prev_qv = 1'b0;
    int            qv_cycles = 0, qv_runs = 0, done_cnt = 0, bad_wr = 0, mon_last_qv = 0;
    logic [63:0]   wr_q [$];
    logic          user_q [$];
    logic          last_q [$];
    logic [DW-1:0] qin_q [$];
    logic [63:0]   stall_q [$];

    always @(negedge clk) begin
        mon_pop      = isif_read;
        mon_in_valid = qr_in_valid;
        mon_in_data  = qr_in_data;
        if (qr_in_valid) begin
            qv_cycles++;
            qin_q.push_back(qr_in_data);
            mon_last_qv = cyc;
            if (!prev_qv) qv_runs++;
        end
        prev_qv = qr_in_valid;
        if (osif_write) begin
            wr_q.push_back(osif_data_din);
            user_q.push_back(osif_user_din);
            last_q.push_back(osif_last_din);
            if (!osif_full_n) bad_wr++;
        end
        if (!osif_full_n && busy) stall_q.push_back(osif_data_din);
        if (done) done_cnt++;
    end

    // Engine transform: any fixed bijection-like mix is fine, the controller never looks inside.
    function automatic logic [DW-1:0] eng_f(input logic [DW-1:0] x);
        return (x * 52'd3) ^ {x[12:0], x[51:13]} ^ 52'h5_A5A5_0F0F_3C3C;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mon_pop && in_q.size() > 0) void'(in_q.pop_front());
        tog = !tog;
        isif_empty_n = (in_q.size() > 0) && (!in_stall || tog);
        if (in_q.size() > 0) begin
            isif_data_dout = in_q[0].data;
            isif_last_dout = in_q[0].last;
        end else begin
            isif_data_dout = {$urandom, $urandom};
            isif_last_dout = 1'($urandom_range(1));
        end
        if (mon_in_valid) begin
            rq.push_back(eng_f(mon_in_data));
            rd.push_back(cyc - 1 + lat);
        end
        if (eng_on && rq.size() > 0 && rd[0] <= cyc &&
            (!eng_gaps || gap_run >= 2 || $urandom_range(3) != 0)) begin
            qr_out_valid = 1'b1;
            qr_out_data  = rq.pop_front();
            void'(rd.pop_front());
            gap_run = 0;
        end else begin
            qr_out_valid = 1'b0;
            qr_out_data  = 52'({$urandom, $urandom});
            if (rq.size() > 0 && rd[0] <= cyc) gap_run++;
        end
        if (bp_left > 0) begin
            osif_full_n = 1'b0;
            bp_left--;
        end else begin
            osif_full_n = rnd_bp ? ($urandom_range(3) != 0) : 1'b1;
        end
        #1;
    endtask

    task automatic push_matrix(input int n_beats, input int last_pos);
        beat_t b;
        for (int k = 0; k < n_beats; k++) begin
            cur_w[k] = 52'({$urandom, $urandom});
            b.data   = {12'($urandom), cur_w[k]};
            b.last   = (k == last_pos);
            in_q.push_back(b);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 64'({isif_read, osif_write, osif_last_din, osif_user_din,
                                  qr_in_valid, busy, done, err_len, err_timeout}), 64'd0);
        check({tag, "_odata"}, osif_data_din, 64'd0);
        check({tag, "_qdata"}, 64'(qr_in_data), 64'd0);
        check({tag, "_mat"}, 64'(mat_cnt), 64'd0);
        check({tag, "_strb"}, 64'(osif_strb_din), 64'hFF);
    endtask

    // One full matrix through LOAD/FEED/WAIT/DRAIN; bp_at > 0 stalls the output FIFO
    // for 5 cycles right after result beat bp_at-1 is written.
    task automatic run_matrix(input string tag, input int last_pos, input int bp_at, input bit pre);
        int  b_wr, b_qv, b_runs, b_qin, b_done, b_stall, n;
        bit  bp_fired;
        b_wr = wr_q.size(); b_qv = qv_cycles; b_runs = qv_runs; b_qin = qin_q.size();
        b_done = done_cnt; b_stall = stall_q.size();
        if (!pre) push_matrix(NC, last_pos);
        exp_mat  = (exp_mat + 1) % 65536;
        bp_fired = 0;
        n        = 0;
        while (done_cnt == b_done && n < 500) begin
            tick();
            n++;
            if (bp_at > 0 && !bp_fired && osif_write && (wr_q.size() - b_wr == bp_at - 1)) begin
                bp_left  = 5;
                bp_fired = 1;
            end
        end
        check({tag, "_done"}, 64'(done_cnt - b_done), 64'd1);
        tick();
        check({tag, "_done_1cyc"}, 64'(done_cnt - b_done), 64'd1);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_nwr"}, 64'(wr_q.size() - b_wr), 64'(NC));
        check({tag, "_mat"}, 64'(mat_cnt), 64'(exp_mat));
        check({tag, "_qv_len"}, 64'(qv_cycles - b_qv), 64'(NC));
        check({tag, "_qv_runs"}, 64'(qv_runs - b_runs), 64'd1);
        check({tag, "_pops"}, 64'(in_q.size()), 64'd0);
        check({tag, "_bad_wr"}, 64'(bad_wr), 64'd0);
        if (wr_q.size() >= b_wr + NC && qin_q.size() >= b_qin + NC) begin
            for (int k = 0; k < NC; k++) begin
                check($sformatf("%s_qin%0d", tag, k), 64'(qin_q[b_qin + k]), 64'(cur_w[k]));
                check($sformatf("%s_d%0d", tag, k), wr_q[b_wr + k], 64'(eng_f(cur_w[k])));
                check($sformatf("%s_ul%0d", tag, k), 64'({user_q[b_wr + k], last_q[b_wr + k]}),
                      64'({k == 0, k == NC - 1}));
            end
        end
        if (bp_at > 0) begin
            check({tag, "_nstall"}, 64'(stall_q.size() - b_stall), 64'd5);
            for (int s = b_stall; s < stall_q.size(); s++)
                check($sformatf("%s_hold%0d", tag, s - b_stall), stall_q[s],
                      64'(eng_f(cur_w[bp_at])));
        end
    endtask

    initial begin
        int b0, b1, b2, n;
        rst = 1'b0; cfg_en = 1'b1;
        isif_data_dout = '0; isif_last_dout = 1'b0; isif_empty_n = 1'b0;
        osif_full_n = 1'b1; qr_out_valid = 1'b0; qr_out_data = '0;
        in_stall = 0; tog = 0; rnd_bp = 0; eng_on = 1; eng_gaps = 0;
        lat = 20; bp_left = 0; gap_run = 0; exp_mat = 0;

        repeat (3) tick();
        check_reset_outputs("por");
        rst = 1'b1;
        tick(); tick();
        check("por_idle", 64'(busy), 64'd0);

        run_matrix("nom", NC - 1, 0, 0);
        in_stall = 1;
        run_matrix("stall", NC - 1, 0, 0);
        in_stall = 0;
        run_matrix("bp", NC - 1, 4, 0);

        // reset in the middle of DRAIN, after result beats 0..2 are out
        b0 = wr_q.size();
        push_matrix(NC, NC - 1);
        n = 0;
        while (wr_q.size() - b0 < 3 && n < 500) begin
            tick();
            n++;
        end
        check("rstd_reach", 64'(wr_q.size() - b0), 64'd3);
        rst = 1'b0;
        #1;
        in_q.delete(); rq.delete(); rd.delete(); bp_left = 0;
        check_reset_outputs("rstd_in");
        tick();
        check_reset_outputs("rstd_hold");
        rst = 1'b1;
        exp_mat = 0;
        repeat (4) tick();
        check("rstd_idle", 64'(busy), 64'd0);
        check("rstd_mat", 64'(mat_cnt), 64'd0);
        check("rstd_nowr", 64'(wr_q.size() - b0), 64'd3);

        // framing error: last on beat 4
        b0 = qv_cycles;
        push_matrix(5, 4);
        n = 0;
        while (!err_len && n < 200) begin
            tick();
            n++;
        end
        check("frm_err", 64'(err_len), 64'd1);
        repeat (3) tick();
        check("frm_idle", 64'(busy), 64'd0);
        check("frm_noqv", 64'(qv_cycles - b0), 64'd0);
        check("frm_pops", 64'(in_q.size()), 64'd0);
        run_matrix("frm_next", NC - 1, 0, 0);
        check("frm_sticky", 64'(err_len), 64'd1);

        // missing last on the final beat: flagged but the matrix still completes
        rst = 1'b0;
        #1;
        tick();
        rst = 1'b1;
        exp_mat = 0;
        tick();
        check("nl_clr", 64'(err_len), 64'd0);
        run_matrix("nolast", -1, 0, 0);
        check("nl_err", 64'(err_len), 64'd1);

        // engine never answers
        eng_on = 0;
        b0 = wr_q.size(); b1 = qv_cycles; b2 = done_cnt;
        push_matrix(NC, NC - 1);
        n = 0;
        while (!err_timeout && n < 300) begin
            tick();
            n++;
        end
        check("to_flag", 64'(err_timeout), 64'd1);
        check("to_delay", 64'(cyc - (mon_last_qv + 1)), 64'd16);
        check("to_idle", 64'(busy), 64'd0);
        repeat (4) tick();
        check("to_nowr", 64'(wr_q.size() - b0), 64'd0);
        check("to_qv", 64'(qv_cycles - b1), 64'(NC));
        check("to_nodone", 64'(done_cnt - b2), 64'd0);
        check("to_mat", 64'(mat_cnt), 64'(exp_mat));
        rq.delete(); rd.delete();
        eng_on = 1;

        // cfg_en low holds off a waiting matrix
        cfg_en = 1'b0;
        push_matrix(NC, NC - 1);
        repeat (10) tick();
        check("cfg_hold_busy", 64'(busy), 64'd0);
        check("cfg_hold_q", 64'(in_q.size()), 64'(NC));
        cfg_en = 1'b1;
        run_matrix("cfg_go", NC - 1, 0, 1);

        // randomized stalls, backpressure, engine latency and result gaps
        rnd_bp = 1; eng_gaps = 1;
        for (int r = 0; r < 6; r++) begin
            in_stall = 1'($urandom_range(1));
            lat      = $urandom_range(8, 20);
            run_matrix($sformatf("rnd%0d", r), NC - 1, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
